dac_write_sequencer: RTL and testbench

Output stage that drives the parallel 16-bit DAC. Accepts samples over a valid/ready handshake into a small FIFO. On each `update_tick` it pops one sample and runs a fixed chip-select / write / load-DAC strobe sequence on the DAC pins, with programmable setup, pulse and hold widths. Sits directly downstream of the sample playback buffer and replaces free-running direct pin toggling with a timed, back-pressured write engine.

---
 rtl/dac_write_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_dac_write_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dac_write_sequencer.sv
// Timed DAC write engine: sample FIFO feeding a CS/WR/LDAC strobe sequencer, one write per update tick.
// Optional build macro DAC_OFFSET_BINARY_EN converts two's-complement samples to offset binary (MSB inverted).
module dac_write_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP_CYC  = 2,
  parameter int WR_CYC     = 2,
  parameter int HOLD_CYC   = 1,
  parameter int LDAC_CYC   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sample_data,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic        update_tick,
  input  logic        stat_clr,
  output logic [15:0] dac_data,
  output logic        dac_cs_n,
  output logic        dac_wr_n,
  output logic        dac_ldac_n,
  output logic        dac_clr_n,
  output logic        busy,
  output logic [15:0] underrun_cnt,
  output logic        tick_overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int MaxSw = (SETUP_CYC > WR_CYC) ? SETUP_CYC : WR_CYC;
  localparam int MaxHl = (HOLD_CYC > LDAC_CYC) ? HOLD_CYC : LDAC_CYC;
  localparam int MaxCyc = (MaxSw > MaxHl) ? MaxSw : MaxHl;
  localparam int CW = (MaxCyc < 2) ? 1 : $clog2(MaxCyc);

  localparam logic [AW:0]   PtrOne = 1;
  localparam logic [CW-1:0] CntOne = 1;

`ifdef DAC_OFFSET_BINARY_EN
  localparam logic [15:0] DataXor = 16'h8000;
`else
  localparam logic [15:0] DataXor = 16'h0000;
`endif

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WRITE,
    HOLD,
    LOAD
  } seqState_e;

  logic [15:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wrPtr_q, wrPtr_d;
  logic [AW:0] rdPtr_q, rdPtr_d;
  logic        fifoFull;
  logic        fifoEmpty;
  logic        push;
  logic        pop;
  logic [15:0] fifoHead;

  seqState_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [15:0] data_q;
  logic        csN_q, wrN_q, ldacN_q, clrN_q, busy_q;
  logic [15:0] underrun_q;
  logic        overrun_q;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign fifoEmpty = (wrPtr_q == rdPtr_q);
  assign fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign fifoHead  = mem_q[rdPtr_q[AW-1:0]];

  assign sample_ready = !fifoFull;
  assign push = sample_valid && !fifoFull;
  assign pop  = (state_q == IDLE) && update_tick && !fifoEmpty;

  always_comb begin
    wrPtr_d = push ? (wrPtr_q + PtrOne) : wrPtr_q;
    rdPtr_d = pop  ? (rdPtr_q + PtrOne) : rdPtr_q;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q[AW-1:0]] <= sample_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Each state reloads the shared down-counter with its width minus one on entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= DataXor;
      csN_q   <= 1'b1;
      wrN_q   <= 1'b1;
      ldacN_q <= 1'b1;
      clrN_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      clrN_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q <= SETUP;
            cnt_q   <= CW'(SETUP_CYC - 1);
            data_q  <= fifoHead ^ DataXor;
            csN_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt_q == '0) begin
            state_q <= WRITE;
            cnt_q   <= CW'(WR_CYC - 1);
            wrN_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end
        WRITE: begin
          if (cnt_q == '0) begin
            state_q <= HOLD;
            cnt_q   <= CW'(HOLD_CYC - 1);
            wrN_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            state_q <= LOAD;
            cnt_q   <= CW'(LDAC_CYC - 1);
            csN_q   <= 1'b1;
            ldacN_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end
        LOAD: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            ldacN_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end
        default: begin
          state_q <= IDLE;
          csN_q   <= 1'b1;
          wrN_q   <= 1'b1;
          ldacN_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // A clear in the same cycle as an underrun or overrun event takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underrun_q <= '0;
      overrun_q  <= 1'b0;
    end else if (stat_clr) begin
      underrun_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      if ((state_q == IDLE) && update_tick && fifoEmpty && (underrun_q != 16'hFFFF)) begin
        underrun_q <= underrun_q + 16'd1;
      end
      if ((state_q != IDLE) && update_tick) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign dac_data     = data_q;
  assign dac_cs_n     = csN_q;
  assign dac_wr_n     = wrN_q;
  assign dac_ldac_n   = ldacN_q;
  assign dac_clr_n    = clrN_q;
  assign busy         = busy_q;
  assign underrun_cnt = underrun_q;
  assign tick_overrun = overrun_q;

endmodule

// File: tb/tb_dac_write_sequencer.sv
// Directed bench for dac_write_sequencer: strobe timing, FIFO back-pressure, underrun/overrun status, async reset.
module tb_dac_write_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        update_tick;
  logic        stat_clr;
  logic [15:0] dac_data;
  logic        dac_cs_n;
  logic        dac_wr_n;
  logic        dac_ldac_n;
  logic        dac_clr_n;
  logic        busy;
  logic [15:0] underrun_cnt;
  logic        tick_overrun;

  int passCount  = 0;
  int checkCount = 0;
  int failCount  = 0;

`ifdef DAC_OFFSET_BINARY_EN
  localparam logic [15:0] XorVal = 16'h8000;
`else
  localparam logic [15:0] XorVal = 16'h0000;
`endif

  dac_write_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .update_tick  (update_tick),
    .stat_clr     (stat_clr),
    .dac_data     (dac_data),
    .dac_cs_n     (dac_cs_n),
    .dac_wr_n     (dac_wr_n),
    .dac_ldac_n   (dac_ldac_n),
    .dac_clr_n    (dac_clr_n),
    .busy         (busy),
    .underrun_cnt (underrun_cnt),
    .tick_overrun (tick_overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of inputs, lets an edge sample them, then returns every input to idle.
  task automatic applyStimulus(input logic valid, input logic [15:0] data,
                               input logic tick, input logic clr);
    sample_valid = valid;
    sample_data  = data;
    update_tick  = tick;
    stat_clr     = clr;
    step();
    sample_valid = 1'b0;
    sample_data  = 16'h0000;
    update_tick  = 1'b0;
    stat_clr     = 1'b0;
  endtask

  task automatic doUpdate(input logic [15:0] expWord);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("ordered word", dac_data, expWord ^ XorVal);
    repeat (7) step();
    checkOutput("ordered done busy", {15'd0, busy}, 16'd0);
  endtask

  initial begin
    int wrLow;
    reset        = 1'b1;
    sample_valid = 1'b0;
    sample_data  = 16'h0000;
    update_tick  = 1'b0;
    stat_clr     = 1'b0;

    #2;
    checkOutput("rst dac_data", dac_data, XorVal);
    checkOutput("rst cs_n", {15'd0, dac_cs_n}, 16'd1);
    checkOutput("rst wr_n", {15'd0, dac_wr_n}, 16'd1);
    checkOutput("rst ldac_n", {15'd0, dac_ldac_n}, 16'd1);
    checkOutput("rst clr_n", {15'd0, dac_clr_n}, 16'd0);
    checkOutput("rst busy", {15'd0, busy}, 16'd0);
    checkOutput("rst underrun", underrun_cnt, 16'd0);
    checkOutput("rst overrun", {15'd0, tick_overrun}, 16'd0);
    checkOutput("rst ready", {15'd0, sample_ready}, 16'd1);
    step();
    step();
    checkOutput("clr_n held in reset", {15'd0, dac_clr_n}, 16'd0);
    reset = 1'b0;
    step();
    checkOutput("clr_n after reset", {15'd0, dac_clr_n}, 16'd1);

    // Single write with full strobe timing walk.
    applyStimulus(1'b1, 16'h5555, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("T data", dac_data, 16'h5555 ^ XorVal);
    checkOutput("T cs_n", {15'd0, dac_cs_n}, 16'd0);
    checkOutput("T wr_n", {15'd0, dac_wr_n}, 16'd1);
    checkOutput("T busy", {15'd0, busy}, 16'd1);
    for (int k = 1; k <= 7; k++) begin
      step();
      checkOutput($sformatf("T+%0d wr_n", k), {15'd0, dac_wr_n}, (k == 2 || k == 3) ? 16'd0 : 16'd1);
      checkOutput($sformatf("T+%0d cs_n", k), {15'd0, dac_cs_n}, (k <= 4) ? 16'd0 : 16'd1);
      checkOutput($sformatf("T+%0d ldac_n", k), {15'd0, dac_ldac_n}, (k == 5 || k == 6) ? 16'd0 : 16'd1);
      checkOutput($sformatf("T+%0d busy", k), {15'd0, busy}, (k < 7) ? 16'd1 : 16'd0);
      checkOutput($sformatf("T+%0d data", k), dac_data, 16'h5555 ^ XorVal);
    end

    // Fill the FIFO, hold a fifth word until a pop frees a slot.
    sample_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample_data = 16'hA001 + 16'(i);
      step();
    end
    checkOutput("full ready", {15'd0, sample_ready}, 16'd0);
    sample_data = 16'hA005;
    step();
    step();
    checkOutput("held ready", {15'd0, sample_ready}, 16'd0);
    update_tick = 1'b1;
    step();
    update_tick = 1'b0;
    checkOutput("pop ready", {15'd0, sample_ready}, 16'd1);
    checkOutput("first word", dac_data, 16'hA001 ^ XorVal);
    step();
    checkOutput("fifth accepted", {15'd0, sample_ready}, 16'd0);
    sample_valid = 1'b0;
    repeat (6) step();
    checkOutput("first done busy", {15'd0, busy}, 16'd0);
    doUpdate(16'hA002);
    doUpdate(16'hA003);
    doUpdate(16'hA004);
    doUpdate(16'hA005);
    checkOutput("drained overrun", {15'd0, tick_overrun}, 16'd0);

    // Ticks on an empty FIFO.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
      checkOutput("underrun cs_n", {15'd0, dac_cs_n}, 16'd1);
      checkOutput("underrun busy", {15'd0, busy}, 16'd0);
    end
    checkOutput("underrun count", underrun_cnt, 16'd3);
    checkOutput("underrun data", dac_data, 16'hA005 ^ XorVal);
    checkOutput("underrun no overrun", {15'd0, tick_overrun}, 16'd0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
    checkOutput("clear wins count", underrun_cnt, 16'd0);

    // Second tick three cycles into a sequence.
    applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h4321, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    wrLow = (dac_wr_n == 1'b0) ? 1 : 0;
    for (int k = 1; k <= 11; k++) begin
      update_tick = (k == 3);
      step();
      if (dac_wr_n == 1'b0) wrLow++;
    end
    update_tick = 1'b0;
    checkOutput("overrun one write", 16'(wrLow), 16'd2);
    checkOutput("overrun flag", {15'd0, tick_overrun}, 16'd1);
    checkOutput("overrun data", dac_data, 16'h1234 ^ XorVal);
    checkOutput("overrun idle", {15'd0, busy}, 16'd0);
    checkOutput("overrun no underrun", underrun_cnt, 16'd0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
    checkOutput("overrun cleared", {15'd0, tick_overrun}, 16'd0);

    // Asynchronous reset while the write strobe is low.
    applyStimulus(1'b1, 16'hBEEF, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("mid data", dac_data, 16'h4321 ^ XorVal);
    step();
    step();
    checkOutput("mid wr_n low", {15'd0, dac_wr_n}, 16'd0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async wr_n", {15'd0, dac_wr_n}, 16'd1);
    checkOutput("async cs_n", {15'd0, dac_cs_n}, 16'd1);
    checkOutput("async ldac_n", {15'd0, dac_ldac_n}, 16'd1);
    checkOutput("async clr_n", {15'd0, dac_clr_n}, 16'd0);
    checkOutput("async busy", {15'd0, busy}, 16'd0);
    checkOutput("async ready", {15'd0, sample_ready}, 16'd1);
    checkOutput("async data", dac_data, XorVal);
    reset = 1'b0;
    step();
    checkOutput("post reset clr_n", {15'd0, dac_clr_n}, 16'd1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("flushed underrun", underrun_cnt, 16'd1);
    checkOutput("flushed busy", {15'd0, busy}, 16'd0);
    checkOutput("flushed data", dac_data, XorVal);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
